// File: rtl/piso_serializer_if.sv
// Handshake and serial-side bundle for piso_serializer.
// The master side is the word producer plus the line driver's strobe.
// The slave side is the serializer itself.
`timescale 1ns/1ps
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             shift;
  logic             serial_out;
  logic             busy;
  logic             bit_last;
  logic             word_done;

  modport master (
    output en, abort, in_data, in_valid, shift,
    input  in_ready, serial_out, busy, bit_last, word_done
  );

  modport slave (
    input  en, abort, in_data, in_valid, shift,
    output in_ready, serial_out, busy, bit_last, word_done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer.
// The buffer lets the next word load on the same edge that retires the
// last bit of the current word, so back-to-back words have no idle gap.
`timescale 1ns/1ps
module piso_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   LSB_FIRST = 1'b0,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  piso_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_valid, hold_valid_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic             word_done_q, word_done_n;
  logic             in_ready_int;
  logic [WIDTH-1:0] sreg_shifted;

  // The buffer only accepts when empty, which keeps accept and the
  // buffer-to-shifter transfer on different edges.
  assign in_ready_int = rst_n & bus.en & ~hold_valid;

  // Move the shift register one bit toward whichever end feeds the line.
  always_comb begin
    sreg_shifted = '0;
    if (LSB_FIRST) begin
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end else begin
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end
  end

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sreg        <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      bit_cnt     <= '0;
      word_done_q <= 1'b0;
    end else begin
      state       <= state_n;
      sreg        <= sreg_n;
      hold        <= hold_n;
      hold_valid  <= hold_valid_n;
      bit_cnt     <= bit_cnt_n;
      word_done_q <= word_done_n;
    end
  end

  // Next-state logic: abort flushes, en=0 freezes, otherwise accept/shift.
  always_comb begin
    state_n      = state;
    sreg_n       = sreg;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    bit_cnt_n    = bit_cnt;
    word_done_n  = 1'b0;

    if (bus.abort) begin
      state_n      = IDLE;
      hold_valid_n = 1'b0;
      bit_cnt_n    = '0;
    end else if (bus.en) begin
      if (bus.in_valid && in_ready_int) begin
        hold_n       = bus.in_data;
        hold_valid_n = 1'b1;
      end

      case (state)
        IDLE: begin
          if (hold_valid) begin
            sreg_n       = hold;
            bit_cnt_n    = CNT_FULL;
            hold_valid_n = 1'b0;
            state_n      = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.shift) begin
            if (bit_cnt > CNT_ONE) begin
              sreg_n    = sreg_shifted;
              bit_cnt_n = bit_cnt - CNT_ONE;
            end else begin
              word_done_n = 1'b1;
              if (hold_valid) begin
                sreg_n       = hold;
                bit_cnt_n    = CNT_FULL;
                hold_valid_n = 1'b0;
              end else begin
                bit_cnt_n = '0;
                state_n   = IDLE;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.serial_out = (state == SHIFT) ? (LSB_FIRST ? sreg[0] : sreg[WIDTH-1])
                                           : IDLE_BIT;
  assign bus.busy       = (state == SHIFT) | hold_valid;
  assign bus.bit_last   = (state == SHIFT) & (bit_cnt == CNT_ONE);
  assign bus.word_done  = word_done_q & bus.en;

endmodule
